// File: rtl/stream_llr_pkg.sv
// rtl/stream_llr_pkg.sv - shared types for the LLR frame reverser
package stream_llr_pkg;

    // Lane width used when a fixed LLR word type is needed outside the top.
    localparam int LLR_BITS = 32;

    typedef logic [LLR_BITS-1:0] llr_word_t;

    // Life cycle of one ping-pong bank.
    typedef enum logic [1:0] {
        FREE     = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    // Read-side sequencer.
    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

endpackage

// File: rtl/stream_llr_frame_reverser_ram.sv
// rtl/stream_llr_frame_reverser_ram.sv - one bank: simple dual-port RAM with registered read
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (read register only)
//   we/waddr/wdata  write port
//   re/raddr        read request; data appears on rdata after the next edge
//   rdata           registered read data, cleared by reset
module llr_bank_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register is reset so the datapath presents zeros after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/stream_llr_frame_reverser.sv
// rtl/stream_llr_frame_reverser.sv - ping-pong frame buffer replaying LLR frames forward or reversed
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_last/in_reverse input symbol handshake, frame end, frame order (first symbol)
//   LLRVector                  input symbol lanes
//   in_ready                   write bank can take a symbol
//   out_valid/out_first/out_last output symbol qualifiers
//   out_index                  original write position of the emitted symbol
//   LLR_D                      output symbol lanes
//   overflow                   sticky: a frame was force-closed at MAX_SYMBOLS
module stream_llr_frame_reverser
    import stream_llr_pkg::*;
#(
    parameter int BITS            = 32,
    parameter int BITS_PER_SYMBOL = 2,
    parameter int MAX_SYMBOLS     = 64,
    parameter int CNT_W           = $clog2(MAX_SYMBOLS + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    input  logic                                  in_last,
    input  logic                                  in_reverse,
    input  logic [BITS_PER_SYMBOL-1:0][BITS-1:0]  LLRVector,
    output logic                                  in_ready,
    output logic                                  out_valid,
    output logic                                  out_first,
    output logic                                  out_last,
    output logic [CNT_W-1:0]                      out_index,
    output logic [BITS_PER_SYMBOL-1:0][BITS-1:0]  LLR_D,
    output logic                                  overflow
);

    localparam int AW = (MAX_SYMBOLS > 1) ? $clog2(MAX_SYMBOLS) : 1;
    localparam int DW = BITS * BITS_PER_SYMBOL;

    // Per-bank bookkeeping, index 0 = bank A, 1 = bank B.
    bank_state_t      bank_st      [2];
    bank_state_t      bank_st_nxt  [2];
    logic [CNT_W-1:0] bank_len     [2];
    logic [CNT_W-1:0] bank_len_nxt [2];
    logic             bank_rev     [2];
    logic             bank_rev_nxt [2];

    // Write side.
    logic             wr_sel;
    logic [AW-1:0]    wr_idx;
    logic             wr_fire;
    logic             wr_at_max;
    logic             wr_close;
    logic             wr_force;

    // Read side.
    rd_state_t        rd_state, rd_state_nxt;
    logic             rd_sel, rd_sel_nxt;
    logic [AW-1:0]    rd_addr, rd_addr_nxt;
    logic [CNT_W-1:0] rd_cnt, rd_cnt_nxt;      // addresses left, including the current one
    logic             rd_rev, rd_rev_nxt;
    logic             rd_first, rd_first_nxt;
    logic             rd_issue;
    logic             rd_final;
    logic             load_bank;
    logic             load;

    // Output alignment: qualifiers follow the address into the read register.
    logic             out_bank;
    logic [DW-1:0]    rdata_a, rdata_b;

    // ------------------------------------------------------------------
    // Write-side decode
    // ------------------------------------------------------------------
    assign in_ready  = (bank_st[wr_sel] == FREE) || (bank_st[wr_sel] == FILLING);
    assign wr_fire   = in_valid && in_ready;
    assign wr_at_max = (wr_idx == AW'(MAX_SYMBOLS - 1));
    assign wr_close  = wr_fire && (in_last || wr_at_max);
    assign wr_force  = wr_fire && !in_last && wr_at_max;

    // ------------------------------------------------------------------
    // Read-side decode
    // ------------------------------------------------------------------
    assign rd_issue  = (rd_state == READ);
    assign rd_final  = rd_issue && (rd_cnt == CNT_W'(1));
    // From IDLE the next frame lives in rd_sel; while finishing a frame the
    // next one (if already complete) lives in the other bank.
    assign load_bank = (rd_state == IDLE) ? rd_sel : ~rd_sel;
    assign load      = (bank_st[load_bank] == FULL) && ((rd_state == IDLE) || rd_final);

    // ------------------------------------------------------------------
    // Next-state logic for banks and read sequencer
    // ------------------------------------------------------------------
    always_comb begin
        bank_st_nxt  = bank_st;
        bank_len_nxt = bank_len;
        bank_rev_nxt = bank_rev;
        rd_state_nxt = rd_state;
        rd_sel_nxt   = rd_sel;
        rd_addr_nxt  = rd_addr;
        rd_cnt_nxt   = rd_cnt;
        rd_rev_nxt   = rd_rev;
        rd_first_nxt = rd_first;

        // The write bank is always FREE/FILLING and the read banks are always
        // FULL/DRAINING, so write and read updates never touch the same bank.
        if (wr_fire) begin
            if (bank_st[wr_sel] == FREE) begin
                bank_st_nxt[wr_sel]  = FILLING;
                bank_rev_nxt[wr_sel] = in_reverse;
            end
            if (wr_close) begin
                bank_st_nxt[wr_sel]  = FULL;
                bank_len_nxt[wr_sel] = CNT_W'(wr_idx) + CNT_W'(1);
            end
        end

        if (rd_issue) begin
            rd_first_nxt = 1'b0;
            rd_cnt_nxt   = rd_cnt - CNT_W'(1);
            rd_addr_nxt  = rd_rev ? (rd_addr - AW'(1)) : (rd_addr + AW'(1));
            if (rd_final) begin
                bank_st_nxt[rd_sel] = FREE;
                rd_sel_nxt          = ~rd_sel;
                rd_state_nxt        = IDLE;
            end
        end

        // Loading a frame overrides the return to IDLE, which keeps output
        // gapless when the other bank completed in time.
        if (load) begin
            bank_st_nxt[load_bank] = DRAINING;
            rd_sel_nxt             = load_bank;
            rd_state_nxt           = READ;
            rd_addr_nxt            = bank_rev[load_bank] ?
                                     AW'(bank_len[load_bank] - CNT_W'(1)) : '0;
            rd_cnt_nxt             = bank_len[load_bank];
            rd_rev_nxt             = bank_rev[load_bank];
            rd_first_nxt           = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st[0]  <= FREE;
            bank_st[1]  <= FREE;
            bank_len[0] <= '0;
            bank_len[1] <= '0;
            bank_rev[0] <= 1'b0;
            bank_rev[1] <= 1'b0;
            rd_state    <= IDLE;
            rd_sel      <= 1'b0;
            rd_addr     <= '0;
            rd_cnt      <= '0;
            rd_rev      <= 1'b0;
            rd_first    <= 1'b0;
        end else begin
            bank_st     <= bank_st_nxt;
            bank_len    <= bank_len_nxt;
            bank_rev    <= bank_rev_nxt;
            rd_state    <= rd_state_nxt;
            rd_sel      <= rd_sel_nxt;
            rd_addr     <= rd_addr_nxt;
            rd_cnt      <= rd_cnt_nxt;
            rd_rev      <= rd_rev_nxt;
            rd_first    <= rd_first_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel   <= 1'b0;
            wr_idx   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_idx <= wr_close ? '0 : (wr_idx + AW'(1));
                if (wr_close) begin
                    wr_sel <= ~wr_sel;
                end
            end
            if (wr_force) begin
                overflow <= 1'b1;
            end
        end
    end

    // Output qualifiers registered alongside the RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_index <= '0;
            out_bank  <= 1'b0;
        end else begin
            out_valid <= rd_issue;
            out_first <= rd_issue && rd_first;
            out_last  <= rd_final;
            if (rd_issue) begin
                out_index <= CNT_W'(rd_addr);
                out_bank  <= rd_sel;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank storage
    // ------------------------------------------------------------------
    llr_bank_ram #(
        .WIDTH (DW),
        .DEPTH (MAX_SYMBOLS),
        .AW    (AW)
    ) u_bank_a (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_fire && (wr_sel == 1'b0)),
        .waddr (wr_idx),
        .wdata (LLRVector),
        .re    (rd_issue && (rd_sel == 1'b0)),
        .raddr (rd_addr),
        .rdata (rdata_a)
    );

    llr_bank_ram #(
        .WIDTH (DW),
        .DEPTH (MAX_SYMBOLS),
        .AW    (AW)
    ) u_bank_b (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_fire && (wr_sel == 1'b1)),
        .waddr (wr_idx),
        .wdata (LLRVector),
        .re    (rd_issue && (rd_sel == 1'b1)),
        .raddr (rd_addr),
        .rdata (rdata_b)
    );

    assign LLR_D = out_bank ? rdata_b : rdata_a;

endmodule

// File: tb/tb_stream_llr_frame_reverser.sv
// tb/tb_stream_llr_frame_reverser.sv - directed self-checking bench for stream_llr_frame_reverser
module tb_stream_llr_frame_reverser;
    import stream_llr_pkg::*;

    typedef struct {
        int          cyc;
        logic        first;
        logic        last;
        logic [6:0]  idx;
        logic [63:0] d;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;

    // Main instance, MAX_SYMBOLS = 64
    logic             in_valid = 1'b0, in_last = 1'b0, in_reverse = 1'b0;
    logic [1:0][31:0] LLRVector = '0;
    logic             in_ready, out_valid, out_first, out_last, overflow;
    logic [6:0]       out_index;
    logic [1:0][31:0] LLR_D;

    // Small instance, MAX_SYMBOLS = 8
    logic             s_in_valid = 1'b0, s_in_last = 1'b0, s_in_reverse = 1'b0;
    logic [1:0][31:0] s_LLRVector = '0;
    logic             s_in_ready, s_out_valid, s_out_first, s_out_last, s_overflow;
    logic [3:0]       s_out_index;
    logic [1:0][31:0] s_LLR_D;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t, stall, guard, n, found;
    rec_t q[$];
    rec_t q2[$];
    logic [63:0] d1[17];
    int   exp2[8];
    llr_word_t pos_one, neg_one;

    stream_llr_frame_reverser #(.BITS(32), .BITS_PER_SYMBOL(2), .MAX_SYMBOLS(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .in_reverse(in_reverse), .LLRVector(LLRVector), .in_ready(in_ready),
        .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
        .out_index(out_index), .LLR_D(LLR_D), .overflow(overflow)
    );

    stream_llr_frame_reverser #(.BITS(32), .BITS_PER_SYMBOL(2), .MAX_SYMBOLS(8)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_last(s_in_last),
        .in_reverse(s_in_reverse), .LLRVector(s_LLRVector), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_first(s_out_first), .out_last(s_out_last),
        .out_index(s_out_index), .LLR_D(s_LLR_D), .overflow(s_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) q.push_back('{cyc, out_first, out_last, out_index, LLR_D});
        if (s_out_valid) q2.push_back('{cyc, s_out_first, s_out_last, {3'b0, s_out_index}, s_LLR_D});
    end

    function automatic logic [63:0] mk(input int f, input int i);
        logic [31:0] v;
        v = 32'h1000_0000 | 32'(f << 8) | 32'(i);
        return {~v, v};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic r, input logic [63:0] d);
        in_valid = v; in_last = l; in_reverse = r; LLRVector = d;
        @(posedge clk); #1;
    endtask

    task automatic sdrive(input logic l, input logic [63:0] d);
        s_in_valid = 1'b1; s_in_last = l; s_in_reverse = 1'b0; s_LLRVector = d;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_last = 1'b0; in_reverse = 1'b0;
        s_in_valid = 1'b0; s_in_last = 1'b0;
    endtask

    task automatic wait_cycles(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    initial begin
        pos_one = 32'h3F80_0000;
        neg_one = 32'hBF80_0000;
        exp2 = '{0, 1, 2, 3, 4, 2, 1, 0};

        // ---------------- reset state ----------------
        wait_cycles(3);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_llr_d", LLR_D, 0);
        chk("rst_out_index", out_index, 0);
        rst_n = 1'b1;
        wait_cycles(1);

        // ---------------- L=17 reverse frame ----------------
        for (int i = 0; i < 17; i++)
            d1[i] = {($urandom_range(0, 1) != 0) ? pos_one : neg_one,
                     ($urandom_range(0, 1) != 0) ? pos_one : neg_one};
        q.delete();
        for (int i = 0; i < 17; i++) drive(1'b1, i == 16, 1'b1, d1[i]);
        t = cyc;
        idle();
        wait_cycles(25);
        chk("rev17_count", q.size(), 17);
        for (int k = 0; k < q.size() && k < 17; k++) begin
            chk("rev17_cyc", q[k].cyc, t + 2 + k);
            chk("rev17_idx", q[k].idx, 16 - k);
            chk("rev17_data", q[k].d, d1[16 - k]);
            chk("rev17_first", q[k].first, k == 0);
            chk("rev17_last", q[k].last, k == 16);
        end

        // ---------------- back-to-back L=5 fwd, L=3 rev ----------------
        q.delete();
        stall = 0;
        for (int i = 0; i < 5; i++) begin
            if (!in_ready) stall++;
            drive(1'b1, i == 4, 1'b0, mk(20, i));
        end
        for (int i = 0; i < 3; i++) begin
            if (!in_ready) stall++;
            drive(1'b1, i == 2, 1'b1, mk(21, i));
        end
        idle();
        chk("b2b_ready_low_count", stall, 0);
        wait_cycles(20);
        chk("b2b_count", q.size(), 8);
        for (int k = 0; k < q.size() && k < 8; k++) begin
            chk("b2b_contig", q[k].cyc, q[0].cyc + k);
            chk("b2b_idx", q[k].idx, exp2[k]);
            chk("b2b_data", q[k].d, (k < 5) ? mk(20, exp2[k]) : mk(21, exp2[k]));
            chk("b2b_first", q[k].first, (k == 0) || (k == 5));
            chk("b2b_last", q[k].last, (k == 4) || (k == 7));
        end

        // ---------------- backpressure: three L=4 frames ----------------
        q.delete();
        for (int i = 0; i < 4; i++) drive(1'b1, i == 3, 1'b0, mk(30, i));
        for (int i = 0; i < 4; i++) drive(1'b1, i == 3, 1'b0, mk(31, i));
        chk("bp_ready_low", in_ready, 0);
        stall = 0;
        guard = 0;
        n = 0;
        while (n < 4 && guard < 40) begin
            guard++;
            if (in_ready) begin
                drive(1'b1, n == 3, 1'b0, mk(32, n));
                n++;
            end else begin
                drive(1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF);
                stall++;
            end
        end
        idle();
        chk("bp_frame3_sent", n, 4);
        chk("bp_stall_cycles", stall, 1);
        wait_cycles(25);
        chk("bp_count", q.size(), 12);
        for (int k = 0; k < q.size() && k < 12; k++) begin
            chk("bp_idx", q[k].idx, k % 4);
            chk("bp_data", q[k].d, mk(30 + k / 4, k % 4));
        end

        // ---------------- overflow, MAX_SYMBOLS=8 ----------------
        q2.delete();
        for (int i = 0; i < 10; i++) begin
            sdrive(i == 9, mk(40, i));
            if (i == 6) chk("ovf_before_8th", s_overflow, 0);
            if (i == 7) chk("ovf_at_8th", s_overflow, 1);
        end
        idle();
        wait_cycles(20);
        chk("ovf_sticky", s_overflow, 1);
        chk("ovf_count", q2.size(), 10);
        for (int k = 0; k < q2.size() && k < 10; k++) begin
            chk("ovf_idx", q2[k].idx, (k < 8) ? k : k - 8);
            chk("ovf_data", q2[k].d, mk(40, k));
            chk("ovf_first", q2[k].first, (k == 0) || (k == 8));
            chk("ovf_last", q2[k].last, (k == 7) || (k == 9));
        end

        // ---------------- L=1 frames, forward then reverse ----------------
        q.delete();
        drive(1'b1, 1'b1, 1'b0, mk(50, 0));
        drive(1'b1, 1'b1, 1'b1, mk(51, 0));
        idle();
        wait_cycles(10);
        chk("l1_count", q.size(), 2);
        for (int k = 0; k < q.size() && k < 2; k++) begin
            chk("l1_first", q[k].first, 1);
            chk("l1_last", q[k].last, 1);
            chk("l1_idx", q[k].idx, 0);
            chk("l1_data", q[k].d, mk(50 + k, 0));
            chk("l1_contig", q[k].cyc, q[0].cyc + k);
        end

        // ---------------- reset mid-drain of L=10 ----------------
        q.delete();
        for (int i = 0; i < 10; i++) drive(1'b1, i == 9, 1'b0, mk(60, i));
        idle();
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            @(negedge clk);
            if (out_valid && out_index == 7'd4) found = 1;
        end
        chk("mid_reached_sym4", found, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_first_last", {out_first, out_last}, 0);
        chk("mid_rst_out_index", out_index, 0);
        chk("mid_rst_llr_d", LLR_D, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_small_ovf", s_overflow, 0);
        wait_cycles(2);
        chk("mid_rst_hold_valid", out_valid, 0);
        rst_n = 1'b1;
        wait_cycles(1);
        q.delete();
        for (int i = 0; i < 3; i++) drive(1'b1, i == 2, 1'b1, mk(61, i));
        t = cyc;
        idle();
        wait_cycles(10);
        chk("post_rst_count", q.size(), 3);
        for (int k = 0; k < q.size() && k < 3; k++) begin
            chk("post_rst_cyc", q[k].cyc, t + 2 + k);
            chk("post_rst_idx", q[k].idx, 2 - k);
            chk("post_rst_data", q[k].d, mk(61, 2 - k));
            chk("post_rst_first", q[k].first, k == 0);
            chk("post_rst_last", q[k].last, k == 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
